// File: rtl/hls_dbg_pkg.sv
// rtl/hls_dbg_pkg.sv - shared record layout and report FSM state for the HLS debug blocks
package hls_dbg_pkg;
    localparam int          RPT_TS_LSB  = 16;
    localparam int          RPT_SRC_LSB = 8;
    localparam logic [7:0]  RPT_RSVD    = 8'h00;

    typedef enum logic {IDLE, SEND} rpt_state_t;
endpackage

// File: rtl/hls_deadlock_run_ctr.sv
// rtl/hls_deadlock_run_ctr.sv - per-source saturating block run counter with trip detect and timestamp capture
module hls_deadlock_run_ctr
    import hls_dbg_pkg::*;
#(
    parameter int THR_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             block,
    input  logic [THR_W-1:0] thr_m1,
    input  logic [TS_W-1:0]  ts,
    output logic             trip,
    output logic             fire,
    output logic [TS_W-1:0]  ts_cap
);
    logic [THR_W-1:0] cnt;

    // Equality compare means a run already past a lowered threshold never trips retroactively.
    always_comb begin
        fire = block && (cnt == thr_m1) && !trip && !clear;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            trip   <= 1'b0;
            ts_cap <= '0;
        end else if (clear) begin
            cnt    <= '0;
            trip   <= 1'b0;
        end else begin
            if (!block)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + THR_W'(1);
            if (fire) begin
                trip   <= 1'b1;
                ts_cap <= ts;
            end
        end
    end
endmodule

// File: rtl/hls_deadlock_reporter.sv
// rtl/hls_deadlock_reporter.sv - persistence filter for HLS deadlock monitors with timestamped trip reports
module hls_deadlock_reporter
    import hls_dbg_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int THR_W   = 16,
    parameter int TS_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] block_in,
    input  logic [THR_W-1:0]   threshold,
    input  logic               clear,
    output logic               deadlock,
    output logic [NUM_SRC-1:0] trip_mask,
    output logic               rpt_tvalid,
    input  logic               rpt_tready,
    output logic [TS_W+15:0]   rpt_tdata
);
    logic [TS_W-1:0]              ts;
    logic [THR_W-1:0]             thr_m1;
    logic [NUM_SRC-1:0]           fire;
    logic [NUM_SRC-1:0]           pending;
    logic [NUM_SRC-1:0][TS_W-1:0] ts_cap;
    logic [NUM_SRC-1:0]           sel_mask;
    logic [NUM_SRC-1:0]           take;
    logic [7:0]                   sel_idx;
    logic [TS_W-1:0]              sel_ts;
    rpt_state_t                   state;

    assign thr_m1 = (threshold == '0) ? '0 : threshold - THR_W'(1);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hls_deadlock_run_ctr #(.THR_W(THR_W), .TS_W(TS_W)) u_ctr (
            .clock  (clock),
            .reset  (reset),
            .clear  (clear),
            .block  (block_in[i]),
            .thr_m1 (thr_m1),
            .ts     (ts),
            .trip   (trip_mask[i]),
            .fire   (fire[i]),
            .ts_cap (ts_cap[i])
        );
    end

    // Lowest pending index wins; scanning downward leaves the lowest one selected.
    always_comb begin
        sel_idx  = '0;
        sel_ts   = '0;
        sel_mask = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx     = 8'(i);
                sel_ts      = ts_cap[i];
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    assign take = (state == IDLE && !clear) ? sel_mask : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts         <= '0;
            pending    <= '0;
            deadlock   <= 1'b0;
            state      <= IDLE;
            rpt_tvalid <= 1'b0;
            rpt_tdata  <= '0;
        end else begin
            ts       <= ts + TS_W'(1);
            deadlock <= !clear && ((trip_mask | fire) != '0);
            pending  <= clear ? '0 : ((pending | fire) & ~take);
            case (state)
                IDLE: begin
                    if (pending != '0 && !clear) begin
                        rpt_tdata[RPT_TS_LSB +: TS_W] <= sel_ts;
                        rpt_tdata[RPT_SRC_LSB +: 8]   <= sel_idx;
                        rpt_tdata[7:0]                <= RPT_RSVD;
                        rpt_tvalid                    <= 1'b1;
                        state                         <= SEND;
                    end
                end
                SEND: begin
                    // A stalled record survives clear; only the handshake retires it.
                    if (rpt_tready) begin
                        rpt_tvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// tb/tb_hls_deadlock_reporter.sv - directed self-checking bench for hls_deadlock_reporter
module tb_hls_deadlock_reporter;
    localparam int NUM_SRC = 4;
    localparam int THR_W   = 4;
    localparam int TS_W    = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_SRC-1:0] block_in = '0;
    logic [THR_W-1:0]   threshold = '0;
    logic               clear = 1'b0;
    logic               deadlock;
    logic [NUM_SRC-1:0] trip_mask;
    logic               rpt_tvalid;
    logic               rpt_tready = 1'b0;
    logic [TS_W+15:0]   rpt_tdata;

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;
    int rec_cnt   = 0;

    hls_deadlock_reporter #(.NUM_SRC(NUM_SRC), .THR_W(THR_W), .TS_W(TS_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .block_in   (block_in),
        .threshold  (threshold),
        .clear      (clear),
        .deadlock   (deadlock),
        .trip_mask  (trip_mask),
        .rpt_tvalid (rpt_tvalid),
        .rpt_tready (rpt_tready),
        .rpt_tdata  (rpt_tdata)
    );

    always #5 clock = ~clock;

    // cyc equals the cycle number since reset release, i.e. the expected timestamp.
    always @(posedge clock) begin
        cyc <= reset ? 0 : cyc + 1;
        if (!reset && rpt_tvalid && rpt_tready) rec_cnt <= rec_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        tests_run++;
        if ({deadlock, trip_mask, rpt_tvalid, rpt_tdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got dl=%b mask=%b v=%b d=%h, need all 0", deadlock, trip_mask, rpt_tvalid, rpt_tdata);
        end
    endtask

    task automatic test_basic_trip();
        int r0;
        r0 = rec_cnt;
        threshold  = 4'd5;
        rpt_tready = 1'b1;
        step(10);
        block_in = 4'b0100;
        step(4);
        tests_run++;
        if (trip_mask !== 4'b0000) begin
            fails++;
            $display("FAIL basic_early: mask=%b, need 0000 at cycle 14", trip_mask);
        end
        step(1);
        block_in = 4'b0000;
        tests_run++;
        if (trip_mask !== 4'b0100 || deadlock !== 1'b1) begin
            fails++;
            $display("FAIL basic_trip: mask=%b dl=%b, need 0100 1", trip_mask, deadlock);
        end
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b1 || rpt_tdata !== 24'h0E0200) begin
            fails++;
            $display("FAIL basic_record: v=%b d=%h, need 1 0e0200", rpt_tvalid, rpt_tdata);
        end
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b0 || rec_cnt - r0 !== 1) begin
            fails++;
            $display("FAIL basic_count: v=%b recs=%0d, need 0 1", rpt_tvalid, rec_cnt - r0);
        end
    endtask

    task automatic test_below_threshold();
        int r0;
        bit bad;
        pulse_clear();
        r0  = rec_cnt;
        bad = 0;
        threshold = 4'd5;
        for (int i = 0; i < 12; i++) begin
            block_in = (i == 4 || i >= 9) ? 4'b0000 : 4'b0001;
            step(1);
            if (deadlock !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad || trip_mask !== 4'b0000 || rec_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL below_thr: dl_seen=%b mask=%b recs=%0d, need 0 0000 0", bad, trip_mask, rec_cnt - r0);
        end
    endtask

    task automatic test_simultaneous_backpressure();
        logic [7:0] ets;
        bit bad;
        pulse_clear();
        threshold  = 4'd3;
        rpt_tready = 1'b0;
        ets        = 8'(cyc + 2);
        block_in   = 4'b1010;
        step(3);
        block_in = 4'b0000;
        tests_run++;
        if (trip_mask !== 4'b1010 || deadlock !== 1'b1) begin
            fails++;
            $display("FAIL simul_trip: mask=%b dl=%b, need 1010 1", trip_mask, deadlock);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (rpt_tvalid !== 1'b1 || rpt_tdata !== {ets, 8'd1, 8'h00}) bad = 1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL simul_hold: v=%b d=%h, need 1 %h0100 for 6 cycles", rpt_tvalid, rpt_tdata, ets);
        end
        rpt_tready = 1'b1;
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL simul_gap: v=%b, need 0", rpt_tvalid);
        end
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b1 || rpt_tdata !== {ets, 8'd3, 8'h00}) begin
            fails++;
            $display("FAIL simul_second: v=%b d=%h, need 1 %h0300", rpt_tvalid, rpt_tdata, ets);
        end
        step(1);
    endtask

    task automatic test_clear_during_send();
        logic [7:0] ets;
        int r0;
        bit bad;
        pulse_clear();
        threshold  = 4'd2;
        rpt_tready = 1'b0;
        ets        = 8'(cyc + 1);
        block_in   = 4'b0011;
        step(2);
        block_in = 4'b0000;
        step(1);
        r0    = rec_cnt;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        tests_run++;
        if (trip_mask !== 4'b0000 || deadlock !== 1'b0) begin
            fails++;
            $display("FAIL clr_state: mask=%b dl=%b, need 0000 0", trip_mask, deadlock);
        end
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b1 || rpt_tdata !== {ets, 8'd0, 8'h00}) begin
            fails++;
            $display("FAIL clr_stalled: v=%b d=%h, need 1 %h0000", rpt_tvalid, rpt_tdata, ets);
        end
        rpt_tready = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (rpt_tvalid !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad || rec_cnt - r0 !== 1) begin
            fails++;
            $display("FAIL clr_no_more: extra_valid=%b recs=%0d, need 0 1", bad, rec_cnt - r0);
        end
    endtask

    task automatic test_threshold_zero();
        logic [7:0] ets;
        pulse_clear();
        threshold = 4'd0;
        ets       = 8'(cyc);
        block_in  = 4'b0001;
        step(1);
        block_in = 4'b0000;
        tests_run++;
        if (trip_mask !== 4'b0001 || deadlock !== 1'b1) begin
            fails++;
            $display("FAIL thr0_trip: mask=%b dl=%b, need 0001 1", trip_mask, deadlock);
        end
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b1 || rpt_tdata !== {ets, 8'd0, 8'h00}) begin
            fails++;
            $display("FAIL thr0_record: v=%b d=%h, need 1 %h0000", rpt_tvalid, rpt_tdata, ets);
        end
        step(1);
    endtask

    task automatic test_saturation();
        int r0;
        bit bad;
        pulse_clear();
        r0        = rec_cnt;
        threshold = 4'd15;
        block_in  = 4'b0010;
        step(14);
        tests_run++;
        if (trip_mask !== 4'b0000) begin
            fails++;
            $display("FAIL sat_early: mask=%b, need 0000", trip_mask);
        end
        step(1);
        tests_run++;
        if (trip_mask !== 4'b0010) begin
            fails++;
            $display("FAIL sat_trip: mask=%b, need 0010", trip_mask);
        end
        step(25);
        block_in = 4'b0000;
        step(2);
        tests_run++;
        if (rec_cnt - r0 !== 1 || trip_mask !== 4'b0010) begin
            fails++;
            $display("FAIL sat_once: recs=%0d mask=%b, need 1 0010", rec_cnt - r0, trip_mask);
        end
        // Lower the threshold beneath a live run: it must neither trip nor wrap into a trip.
        pulse_clear();
        threshold = 4'd15;
        block_in  = 4'b0100;
        step(14);
        threshold = 4'd1;
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            step(1);
            if (trip_mask !== 4'b0000) bad = 1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL sat_no_wrap: mask=%b, need 0000 while saturated", trip_mask);
        end
        block_in = 4'b0000;
        step(1);
        block_in = 4'b0100;
        step(1);
        block_in = 4'b0000;
        tests_run++;
        if (trip_mask !== 4'b0100) begin
            fails++;
            $display("FAIL sat_restart: mask=%b, need 0100", trip_mask);
        end
        step(2);
    endtask

    task automatic test_ts_wrap();
        logic [7:0] ets;
        pulse_clear();
        threshold = 4'd1;
        step(300);
        ets      = 8'(cyc);
        block_in = 4'b1000;
        step(1);
        block_in = 4'b0000;
        step(1);
        tests_run++;
        if (rpt_tvalid !== 1'b1 || rpt_tdata !== {ets, 8'd3, 8'h00}) begin
            fails++;
            $display("FAIL ts_wrap: v=%b d=%h, need 1 %h0300", rpt_tvalid, rpt_tdata, ets);
        end
        step(1);
    endtask

    task automatic test_reset_mid_send();
        int r0;
        pulse_clear();
        threshold  = 4'd1;
        rpt_tready = 1'b0;
        block_in   = 4'b0001;
        step(1);
        block_in = 4'b0000;
        step(1);
        r0    = rec_cnt;
        reset = 1'b1;
        step(1);
        tests_run++;
        if ({deadlock, trip_mask, rpt_tvalid, rpt_tdata} !== '0) begin
            fails++;
            $display("FAIL reset_send: dl=%b mask=%b v=%b d=%h, need all 0", deadlock, trip_mask, rpt_tvalid, rpt_tdata);
        end
        reset      = 1'b0;
        rpt_tready = 1'b1;
        step(5);
        tests_run++;
        if (rpt_tvalid !== 1'b0 || rec_cnt - r0 !== 0 || trip_mask !== 4'b0000) begin
            fails++;
            $display("FAIL reset_replay: v=%b recs=%0d mask=%b, need 0 0 0000", rpt_tvalid, rec_cnt - r0, trip_mask);
        end
    endtask

    initial begin
        test_reset();
        test_basic_trip();
        test_below_threshold();
        test_simultaneous_backpressure();
        test_clear_during_send();
        test_threshold_zero();
        test_saturation();
        test_ts_wrap();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
